gate_selftest_seq: RTL and testbench

Self-test sequencer for a 2-input combinational gate. On `start` it drives the four input combinations into the gate under test in a fixed order and holds each for a programmable settle time. It samples the gate output at the end of each hold, compares it with an expected truth table, and reports pass/fail, a mismatch count and a per-vector failure mask. It sits beside the gate in place of the hand-written stimulus block and lets the gate be checked in-system, cycle-accurately, with no testbench involvement.

---
 rtl/gate_selftest_seq.sv | 154 +++++++++++++++
 tb/tb_gate_selftest_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_selftest_seq.sv
// rtl/gate_selftest_seq.sv - self-test sequencer for a 2-input combinational gate
//
// Purpose:
//   On start, walks the four input vectors k = {B,A} = 0,1,2,3 into the gate
//   under test, holds each for SETTLE+1 cycles, samples gate_out at the end of
//   each hold and compares it with TRUTH[k]. Reports pass, a mismatch count
//   and a per-vector failure mask.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   begin a run (honoured only in IDLE)
//   gate_out   in   output of the gate under test
//   gate_a     out  gate input A (registered)
//   gate_b     out  gate input B (registered)
//   busy       out  high while vectors are driven
//   done       out  one-cycle pulse at run completion
//   pass       out  last completed run had zero mismatches
//   err_count  out  mismatching vectors in the last run (0..4)
//   fail_vec   out  bit k set if vector k mismatched
module gate_selftest_seq #(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_out,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] RELOAD = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] k, k_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       gate_a_nxt, gate_b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [2:0] err_nxt;
  logic [3:0] fail_nxt;
  logic       mismatch;
  logic       last_sample;

  // Anything other than an exact match (including X/Z in simulation) is a
  // mismatch: an unknown compare result falls through to the default.
  always_comb begin
    mismatch = 1'b1;
    if (gate_out == TRUTH[k]) mismatch = 1'b0;
  end

  assign last_sample = (cnt == 4'd0) && (k == 2'd3);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (last_sample) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and counters
  always_comb begin
    k_nxt      = k;
    cnt_nxt    = cnt;
    gate_a_nxt = 1'b0;
    gate_b_nxt = 1'b0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    pass_nxt   = pass;
    err_nxt    = err_count;
    fail_nxt   = fail_vec;
    unique case (state)
      IDLE: begin
        if (start) begin
          k_nxt    = 2'd0;
          cnt_nxt  = RELOAD;
          busy_nxt = 1'b1;
          pass_nxt = 1'b0;
          err_nxt  = 3'd0;
          fail_nxt = 4'd0;
        end
      end
      DRIVE: begin
        busy_nxt   = 1'b1;
        gate_a_nxt = k[0];
        gate_b_nxt = k[1];
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          if (mismatch) begin
            fail_nxt[k] = 1'b1;
            err_nxt     = err_count + 3'd1;
          end
          if (k != 2'd3) begin
            k_nxt      = k + 2'd1;
            cnt_nxt    = RELOAD;
            gate_a_nxt = k_nxt[0];
            gate_b_nxt = k_nxt[1];
          end else begin
            busy_nxt   = 1'b0;
            gate_a_nxt = 1'b0;
            gate_b_nxt = 1'b0;
            done_nxt   = 1'b1;
            pass_nxt   = (err_nxt == 3'd0);
          end
        end
      end
      DONE: ;
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k         <= 2'd0;
      cnt       <= 4'd0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      k         <= k_nxt;
      cnt       <= cnt_nxt;
      gate_a    <= gate_a_nxt;
      gate_b    <= gate_b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_nxt;
      fail_vec  <= fail_nxt;
    end
  end

endmodule

// File: tb/tb_gate_selftest_seq.sv
// tb/tb_gate_selftest_seq.sv - self-checking bench for gate_selftest_seq
module tb_gate_selftest_seq;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start;
  logic [2:0] gout, ga, gb, busy, done, pass;
  logic [2:0] ec0, ec1, ec2;
  logic [3:0] fv0, fv1, fv2;
  int         mode_v [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Gate models: 0 AND, 1 stuck0, 2 stuck1, 3 OR, 4 XOR, 5 NAND
  function automatic logic gate_fn(input int mode, input logic a, input logic b);
    case (mode)
      0: return a & b;
      1: return 1'b0;
      2: return 1'b1;
      3: return a | b;
      4: return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Instance 0: AND table, SETTLE=2; 1: OR table, SETTLE=2; 2: AND table, SETTLE=0
  function automatic logic [3:0] truth_of(input int idx);
    return (idx == 1) ? 4'b1110 : 4'b1000;
  endfunction

  function automatic int settle_of(input int idx);
    return (idx == 2) ? 0 : 2;
  endfunction

  function automatic logic [3:0] model_fail(input int idx, input int mode);
    logic [3:0] t, f;
    t = truth_of(idx);
    for (int kk = 0; kk < 4; kk++)
      f[kk] = (gate_fn(mode, kk[0], kk[1]) != t[kk]);
    return f;
  endfunction

  assign gout[0] = gate_fn(mode_v[0], ga[0], gb[0]);
  assign gout[1] = gate_fn(mode_v[1], ga[1], gb[1]);
  assign gout[2] = gate_fn(mode_v[2], ga[2], gb[2]);

  gate_selftest_seq #(.TRUTH(4'b1000), .SETTLE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .gate_out(gout[0]),
    .gate_a(ga[0]), .gate_b(gb[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(ec0), .fail_vec(fv0));

  gate_selftest_seq #(.TRUTH(4'b1110), .SETTLE(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .gate_out(gout[1]),
    .gate_a(ga[1]), .gate_b(gb[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(ec1), .fail_vec(fv1));

  gate_selftest_seq #(.TRUTH(4'b1000), .SETTLE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .gate_out(gout[2]),
    .gate_a(ga[2]), .gate_b(gb[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .err_count(ec2), .fail_vec(fv2));

  // {busy, done, gate_b, gate_a}
  function automatic logic [3:0] ctl(input int idx);
    return {busy[idx], done[idx], gb[idx], ga[idx]};
  endfunction

  // {pass, err_count, fail_vec}
  function automatic logic [7:0] res(input int idx);
    case (idx)
      0: return {pass[0], ec0, fv0};
      1: return {pass[1], ec1, fv1};
      default: return {pass[2], ec2, fv2};
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Start a run on instance idx and check every cycle up to T0+4P+1.
  // Called #1 after an edge with the instance idle. pulse_c >= 1 raises start
  // for the edge T0+pulse_c; hold keeps start high and leaves it high.
  task automatic run(input int idx, input int mode, input logic [2:0] e_err,
                     input logic [3:0] e_fail, input int pulse_c, input bit hold);
    int p;
    logic [3:0] exp_ctl, m;
    logic [2:0] n;
    p = settle_of(idx) + 1;
    mode_v[idx] = mode;
    start[idx] = 1'b1;
    @(posedge clk); #1;
    if (!hold) start[idx] = 1'b0;
    for (int c = 0; c <= 4 * p + 1; c++) begin
      if (c < 4 * p) begin
        exp_ctl = {1'b1, 1'b0, 2'(c / p)};
        exp_ctl = {exp_ctl[3:2], exp_ctl[0], exp_ctl[1]} ;
        exp_ctl = {2'b10, 2'(c / p)};
        exp_ctl = {2'b10, exp_ctl[1:0]};
        m = 4'd0; n = 3'd0;
        for (int kk = 0; kk < 4; kk++)
          if ((kk + 1) * p <= c && e_fail[kk]) begin
            m[kk] = 1'b1; n = n + 3'd1;
          end
        chk("ctl_run", 16'(ctl(idx)), 16'(exp_ctl));
        chk("res_partial", 16'(res(idx)), 16'({1'b0, n, m}));
      end else begin
        chk("ctl_end", 16'(ctl(idx)), (c == 4 * p) ? 16'h4 : 16'h0);
        chk("res_final", 16'(res(idx)), 16'({e_err == 3'd0, e_err, e_fail}));
      end
      if (c == pulse_c - 1) start[idx] = 1'b1;
      if (c == pulse_c)     start[idx] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    int         idx;
    int         mode;
    logic [2:0] e_err;
    logic [3:0] e_fail;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{0, 0, 3'd0, 4'b0000};  // correct AND
    tbl[1] = '{0, 1, 3'd1, 4'b1000};  // stuck at 0
    tbl[2] = '{0, 2, 3'd3, 4'b0111};  // stuck at 1
    tbl[3] = '{0, 3, 3'd2, 4'b0110};  // OR vs AND table
    tbl[4] = '{1, 3, 3'd0, 4'b0000};  // OR vs OR table
    tbl[5] = '{0, 4, 3'd3, 4'b1110};  // XOR vs AND table
    tbl[6] = '{2, 0, 3'd0, 4'b0000};  // AND, SETTLE=0

    rst_n = 1'b0;
    start = 3'b000;
    mode_v[0] = 0; mode_v[1] = 0; mode_v[2] = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_ctl", 16'(ctl(i)), 16'h0);
      chk("reset_res", 16'(res(i)), 16'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven runs
    for (int i = 0; i < 7; i++) begin
      run(tbl[i].idx, tbl[i].mode, tbl[i].e_err, tbl[i].e_fail, -1, 1'b0);
      @(posedge clk); #1;
    end

    // Reset for one edge at T0+5 in a run
    mode_v[0] = 0;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      chk("midreset_ctl", 16'(ctl(0)), 16'h0);
      chk("midreset_res", 16'(res(0)), 16'h0);
      @(posedge clk); #1;
    end
    run(0, 1, 3'd1, 4'b1000, -1, 1'b0);
    @(posedge clk); #1;

    // start pulsed at T0+4 is ignored
    run(0, 0, 3'd0, 4'b0000, 4, 1'b0);
    @(posedge clk); #1;

    // start held high: next run starts at T0+4P+2 on each instance kind
    for (int j = 0; j < 3; j += 2) begin
      run(j, 1, 3'd1, 4'b1000, -1, 1'b1);
      chk("restart_ctl", 16'(ctl(j)), 16'h8);
      chk("restart_res", 16'(res(j)), 16'h0);
      start[j] = 1'b0;
      for (int t = 0; t < 100 && !done[j]; t++) begin
        @(posedge clk); #1;
      end
      chk("restart_done", 16'(done[j]), 16'h1);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end

    // Randomized runs against the model
    for (int r = 0; r < 20; r++) begin
      int idx, mode;
      logic [3:0] f;
      logic [2:0] e;
      idx  = int'($urandom_range(0, 2));
      mode = int'($urandom_range(0, 5));
      f = model_fail(idx, mode);
      e = 3'(f[0]) + 3'(f[1]) + 3'(f[2]) + 3'(f[3]);
      run(idx, mode, e, f, -1, 1'b0);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
